// File: rtl/ahb_sram_ctrl.sv
// rtl/ahb_sram_ctrl.sv - AHB-Lite to synchronous SRAM bridge with posted-write buffer; optional ERROR responses under AHB_SRAM_ERR_RESP_EN
module ahb_sram_ctrl #(
    parameter int DATA_W      = 32,
    parameter int MEM_AW      = 17,
    parameter int WAIT_STATES = 0
) (
    input  logic                                   hclk,
    input  logic                                   hrst_b,
    input  logic                                   hsel,
    input  logic                                   hready_in,
    input  logic [1:0]                             htrans,
    input  logic                                   hwrite,
    input  logic [2:0]                             hsize,
    input  logic [31:0]                            haddr,
    input  logic [2:0]                             hburst,
    input  logic [3:0]                             hprot,
    input  logic [DATA_W-1:0]                      hwdata,
    output logic [DATA_W-1:0]                      hrdata,
    output logic                                   hready_out,
    output logic [1:0]                             hresp,
    output logic                                   ram_cs,
    output logic                                   ram_we,
    output logic [DATA_W/8-1:0]                    ram_be,
    output logic [MEM_AW-$clog2(DATA_W/8)-1:0]     ram_addr,
    output logic [DATA_W-1:0]                      ram_wdata,
    input  logic [DATA_W-1:0]                      ram_rdata
);
    localparam int NB  = DATA_W / 8;
    localparam int LB  = $clog2(NB);
    localparam int RAW = MEM_AW - LB;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, ERR1, ERR2} state_t;
    typedef enum logic [1:0] {WB_EMPTY, WB_ADDR, WB_FULL} wb_state_t;

    state_t    state, state_n;
    logic [1:0] cnt, cnt_n;
    wb_state_t wb_state;
    logic [RAW-1:0]    wb_addr;
    logic [NB-1:0]     wb_be;
    logic [DATA_W-1:0] wb_data;
    logic [RAW-1:0]    rd_addr;
    logic              rd_first;
    logic [DATA_W-1:0] rd_hold;
    logic [DATA_W-1:0] rd_merged;

    logic          accepting;
    logic          acc;
    logic          req_err;
    logic          rd_issue;
    logic          wr_accept;
    logic [RAW-1:0] req_addr;
    logic [NB-1:0] req_be;
    int            sz_eff;
    int            nbytes;
    int            lane_off;

    logic unused_bits;
    assign unused_bits = ^{hburst, hprot, haddr[31:MEM_AW]};

    // Only a cycle in which this slave shows ready can start a new address phase
    assign accepting = (state == IDLE) || (state == RD_DATA) || (state == ERR2);
    assign acc       = hsel & hready_in & htrans[1] & accepting;
    assign req_addr  = haddr[MEM_AW-1:LB];

`ifdef AHB_SRAM_ERR_RESP_EN
    assign req_err = (haddr[31:MEM_AW] != '0) || (int'(hsize) > LB) ||
                     ((int'(haddr[LB-1:0]) & ((1 << int'(hsize)) - 1)) != 0);
`else
    assign req_err = 1'b0;
`endif

    assign rd_issue  = acc & ~hwrite & ~req_err & hrst_b;
    assign wr_accept = acc &  hwrite & ~req_err;

    // Byte strobes: oversize transfers clamp to the bus width, offsets align down to the size
    always_comb begin
        sz_eff   = (int'(hsize) > LB) ? LB : int'(hsize);
        nbytes   = 1 << sz_eff;
        lane_off = int'(haddr[LB-1:0]) & ~(nbytes - 1);
        req_be   = '0;
        for (int i = 0; i < NB; i++) begin
            req_be[i] = (i >= lane_off) && (i < lane_off + nbytes);
        end
    end

    // Data-phase state register and wait counter
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Data-phase next state plus handshake/response outputs
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hready_out = 1'b1;
        hresp      = 2'b00;
        case (state)
            IDLE, RD_DATA, ERR2: begin
`ifdef AHB_SRAM_ERR_RESP_EN
                if (state == ERR2) hresp = 2'b01;
`endif
                state_n = IDLE;
                if (acc) begin
                    if (req_err) begin
                        state_n = ERR1;
                    end else if (!hwrite) begin
                        if (WAIT_STATES == 0) begin
                            state_n = RD_DATA;
                        end else begin
                            state_n = RD_WAIT;
                            cnt_n   = 2'(WAIT_STATES - 1);
                        end
                    end
                end
            end
            RD_WAIT: begin
                hready_out = 1'b0;
                if (cnt == 2'd0) state_n = RD_DATA;
                else             cnt_n   = cnt - 2'd1;
            end
            ERR1: begin
                hready_out = 1'b0;
`ifdef AHB_SRAM_ERR_RESP_EN
                hresp      = 2'b01;
`endif
                state_n    = ERR2;
            end
            default: state_n = IDLE;
        endcase
    end

    // One-entry write buffer: ADDR holds a write whose data is on hwdata this cycle;
    // it goes straight to RAM unless a read owns the port, in which case it parks as FULL
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            wb_state <= WB_EMPTY;
            wb_addr  <= '0;
            wb_be    <= '0;
            wb_data  <= '0;
        end else begin
            case (wb_state)
                WB_ADDR: begin
                    if (rd_issue) begin
                        wb_state <= WB_FULL;
                        wb_data  <= hwdata;
                    end else begin
                        wb_state <= WB_EMPTY;
                    end
                end
                WB_FULL: if (!rd_issue) wb_state <= WB_EMPTY;
                default: ;
            endcase
            if (wr_accept) begin
                wb_state <= WB_ADDR;
                wb_addr  <= req_addr;
                wb_be    <= req_be;
            end
        end
    end

    // Read tracking: word address, first data cycle flag and held data for wait states
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            rd_addr  <= '0;
            rd_first <= 1'b0;
            rd_hold  <= '0;
        end else begin
            rd_first <= rd_issue;
            if (rd_issue) rd_addr <= req_addr;
            if (rd_first) rd_hold <= rd_merged;
        end
    end

    // Overlay any not-yet-written buffered bytes so the bus always sees the latest write
    always_comb begin
        rd_merged = ram_rdata;
        for (int i = 0; i < NB; i++) begin
            if (wb_state == WB_FULL && wb_addr == rd_addr && wb_be[i]) begin
                rd_merged[i*8 +: 8] = wb_data[i*8 +: 8];
            end else if (wb_state == WB_ADDR && wb_addr == rd_addr && wb_be[i]) begin
                rd_merged[i*8 +: 8] = hwdata[i*8 +: 8];
            end
        end
    end

    // Read data is only driven in the completing data-phase cycle
    always_comb begin
        hrdata = '0;
        if (state == RD_DATA) hrdata = rd_first ? rd_merged : rd_hold;
    end

    // RAM port: reads take priority, otherwise the buffered write drains
    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = req_addr;
        ram_wdata = wb_data;
        if (rd_issue) begin
            ram_cs = 1'b1;
        end else if (wb_state == WB_FULL) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_be   = wb_be;
            ram_addr = wb_addr;
        end else if (wb_state == WB_ADDR) begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_be    = wb_be;
            ram_addr  = wb_addr;
            ram_wdata = hwdata;
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb/tb_ahb_sram_ctrl.sv - table-driven bench for ahb_sram_ctrl (32-bit zero-wait and 64-bit two-wait instances)
module tb_ahb_sram_ctrl;
    localparam logic [1:0] NS = 2'b10, ID = 2'b00, BZ = 2'b01;
    localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2, SD = 3'd3;
    localparam logic Y = 1'b1, N = 1'b0;

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] rd;
        logic        cs;
        logic        we;
        logic [3:0]  be;
        logic [14:0] ra;
        logic [31:0] rw;
    } vec_t;

    vec_t tbl [0:22];
    int n_vec = 0;
    int n_err = 0;

    logic hclk = 1'b0;
    logic hrst_b;
    always #5 hclk = ~hclk;

    logic        a_sel, a_wr, a_rdy, a_cs, a_we;
    logic [1:0]  a_tr, a_resp;
    logic [2:0]  a_sz;
    logic [31:0] a_ad, a_wd, a_rd, a_rwd, a_rrd;
    logic [3:0]  a_be;
    logic [14:0] a_ra;

    logic        b_sel, b_wr, b_rdy, b_cs, b_we;
    logic [1:0]  b_tr, b_resp;
    logic [2:0]  b_sz;
    logic [31:0] b_ad;
    logic [63:0] b_wd, b_rd, b_rwd, b_rrd;
    logic [7:0]  b_be;
    logic [13:0] b_ra;

    ahb_sram_ctrl #(.DATA_W(32), .MEM_AW(17), .WAIT_STATES(0)) u0 (
        .hclk(hclk), .hrst_b(hrst_b), .hsel(a_sel), .hready_in(a_rdy), .htrans(a_tr),
        .hwrite(a_wr), .hsize(a_sz), .haddr(a_ad), .hburst(3'b000), .hprot(4'b0011),
        .hwdata(a_wd), .hrdata(a_rd), .hready_out(a_rdy), .hresp(a_resp), .ram_cs(a_cs),
        .ram_we(a_we), .ram_be(a_be), .ram_addr(a_ra), .ram_wdata(a_rwd), .ram_rdata(a_rrd)
    );

    ahb_sram_ctrl #(.DATA_W(64), .MEM_AW(17), .WAIT_STATES(2)) u1 (
        .hclk(hclk), .hrst_b(hrst_b), .hsel(b_sel), .hready_in(b_rdy), .htrans(b_tr),
        .hwrite(b_wr), .hsize(b_sz), .haddr(b_ad), .hburst(3'b000), .hprot(4'b0011),
        .hwdata(b_wd), .hrdata(b_rd), .hready_out(b_rdy), .hresp(b_resp), .ram_cs(b_cs),
        .ram_we(b_we), .ram_be(b_be), .ram_addr(b_ra), .ram_wdata(b_rwd), .ram_rdata(b_rrd)
    );

    logic [31:0] mem_a [0:32767];
    logic        init_a = 1'b0;
    always @(posedge hclk) begin
        if (!init_a) begin
            for (int i = 0; i < 32768; i++) mem_a[i] <= 32'hC0DE_0000 | 32'(i);
            init_a <= 1'b1;
        end else if (a_cs) begin
            if (a_we) begin
                for (int l = 0; l < 4; l++) if (a_be[l]) mem_a[a_ra][l*8 +: 8] <= a_rwd[l*8 +: 8];
            end else begin
                a_rrd <= mem_a[a_ra];
            end
        end
    end

    logic [63:0] mem_b [0:16383];
    logic        init_b = 1'b0;
    always @(posedge hclk) begin
        if (!init_b) begin
            for (int i = 0; i < 16384; i++) mem_b[i] <= {32'hFACE_0000 | 32'(i), 32'h0BAD_0000 | 32'(i)};
            init_b <= 1'b1;
        end else if (b_cs) begin
            if (b_we) begin
                for (int l = 0; l < 8; l++) if (b_be[l]) mem_b[b_ra][l*8 +: 8] <= b_rwd[l*8 +: 8];
            end else begin
                b_rrd <= mem_b[b_ra];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd);
        @(posedge hclk);
        #1;
        a_sel = sel; a_tr = tr; a_wr = wr; a_sz = sz; a_ad = ad; a_wd = wd;
        @(negedge hclk);
    endtask

    task automatic drive_b(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                           input logic [31:0] ad, input logic [63:0] wd);
        @(posedge hclk);
        #1;
        b_sel = 1'b1; b_tr = tr; b_wr = wr; b_sz = sz; b_ad = ad; b_wd = wd;
        @(negedge hclk);
    endtask

    initial begin
        //        sel tr  wr sz  addr          wdata           rdy rdata          cs we be    ram_addr  ram_wdata
        tbl[0]  = '{Y, NS, Y, SW, 32'h10, 32'h0,          Y, 32'h0,          N, N, 4'h0, 15'h0,  32'h0};
        tbl[1]  = '{Y, ID, N, SW, 32'h0,  32'hA5A5_5A5A,  Y, 32'h0,          Y, Y, 4'hF, 15'h4,  32'hA5A5_5A5A};
        tbl[2]  = '{Y, NS, N, SW, 32'h10, 32'h0,          Y, 32'h0,          Y, N, 4'h0, 15'h4,  32'h0};
        tbl[3]  = '{Y, NS, Y, SB, 32'h11, 32'h0,          Y, 32'hA5A5_5A5A,  N, N, 4'h0, 15'h0,  32'h0};
        tbl[4]  = '{Y, NS, N, SW, 32'h10, 32'h0000_3C00,  Y, 32'h0,          Y, N, 4'h0, 15'h4,  32'h0};
        tbl[5]  = '{Y, ID, N, SW, 32'h0,  32'h0,          Y, 32'hA5A5_3C5A,  Y, Y, 4'h2, 15'h4,  32'h0000_3C00};
        tbl[6]  = '{Y, NS, N, SW, 32'h10, 32'h0,          Y, 32'h0,          Y, N, 4'h0, 15'h4,  32'h0};
        tbl[7]  = '{Y, ID, N, SW, 32'h0,  32'h0,          Y, 32'hA5A5_3C5A,  N, N, 4'h0, 15'h0,  32'h0};
        tbl[8]  = '{Y, NS, Y, SH, 32'h16, 32'h0,          Y, 32'h0,          N, N, 4'h0, 15'h0,  32'h0};
        tbl[9]  = '{Y, NS, N, SW, 32'h14, 32'h1234_0000,  Y, 32'h0,          Y, N, 4'h0, 15'h5,  32'h0};
        tbl[10] = '{Y, NS, N, SW, 32'h20, 32'h0,          Y, 32'h1234_0005,  Y, N, 4'h0, 15'h8,  32'h0};
        tbl[11] = '{Y, ID, N, SW, 32'h0,  32'h0,          Y, 32'hC0DE_0008,  Y, Y, 4'hC, 15'h5,  32'h1234_0000};
        tbl[12] = '{Y, BZ, N, SW, 32'h30, 32'h0,          Y, 32'h0,          N, N, 4'h0, 15'h0,  32'h0};
        tbl[13] = '{Y, NS, N, SW, 32'h14, 32'h0,          Y, 32'h0,          Y, N, 4'h0, 15'h5,  32'h0};
        tbl[14] = '{Y, ID, N, SW, 32'h0,  32'h0,          Y, 32'h1234_0005,  N, N, 4'h0, 15'h0,  32'h0};
        tbl[15] = '{N, NS, N, SW, 32'h10, 32'h0,          Y, 32'h0,          N, N, 4'h0, 15'h0,  32'h0};
        tbl[16] = '{Y, ID, N, SW, 32'h0,  32'h0,          Y, 32'h0,          N, N, 4'h0, 15'h0,  32'h0};
        tbl[17] = '{Y, NS, Y, SW, 32'h40, 32'h0,          Y, 32'h0,          N, N, 4'h0, 15'h0,  32'h0};
        tbl[18] = '{Y, NS, Y, SW, 32'h44, 32'h1111_1111,  Y, 32'h0,          Y, Y, 4'hF, 15'h10, 32'h1111_1111};
        tbl[19] = '{Y, NS, N, SW, 32'h40, 32'h2222_2222,  Y, 32'h0,          Y, N, 4'h0, 15'h10, 32'h0};
        tbl[20] = '{Y, ID, N, SW, 32'h0,  32'h0,          Y, 32'h1111_1111,  Y, Y, 4'hF, 15'h11, 32'h2222_2222};
        tbl[21] = '{Y, NS, N, SW, 32'h44, 32'h0,          Y, 32'h0,          Y, N, 4'h0, 15'h11, 32'h0};
        tbl[22] = '{Y, ID, N, SW, 32'h0,  32'h0,          Y, 32'h2222_2222,  N, N, 4'h0, 15'h0,  32'h0};

        hrst_b = 1'b0;
        a_sel = 1'b1; a_tr = NS; a_wr = 1'b0; a_sz = SW; a_ad = 32'h10; a_wd = '0;
        b_sel = 1'b1; b_tr = NS; b_wr = 1'b0; b_sz = SD; b_ad = 32'h20; b_wd = '0;
        @(negedge hclk);
        chk("rst.a_rdy",   64'(a_rdy),  64'(1));
        chk("rst.a_resp",  64'(a_resp), 64'(0));
        chk("rst.a_rdata", 64'(a_rd),   64'(0));
        chk("rst.a_cs",    64'(a_cs),   64'(0));
        chk("rst.a_we",    64'(a_we),   64'(0));
        chk("rst.a_be",    64'(a_be),   64'(0));
        chk("rst.b_cs",    64'(b_cs),   64'(0));
        chk("rst.b_rdy",   64'(b_rdy),  64'(1));
        a_tr = ID; b_tr = ID;
        @(negedge hclk);
        hrst_b = 1'b1;

        for (int k = 0; k < 23; k++) begin
            drive_a(tbl[k].sel, tbl[k].tr, tbl[k].wr, tbl[k].sz, tbl[k].ad, tbl[k].wd);
            chk($sformatf("r%0d.rdy", k),   64'(a_rdy),  64'(tbl[k].rdy));
            chk($sformatf("r%0d.resp", k),  64'(a_resp), 64'(0));
            chk($sformatf("r%0d.rdata", k), 64'(a_rd),   64'(tbl[k].rd));
            chk($sformatf("r%0d.cs", k),    64'(a_cs),   64'(tbl[k].cs));
            chk($sformatf("r%0d.we", k),    64'(a_we),   64'(tbl[k].we));
            chk($sformatf("r%0d.be", k),    64'(a_be),   64'(tbl[k].be));
            if (tbl[k].cs) chk($sformatf("r%0d.ram_addr", k), 64'(a_ra), 64'(tbl[k].ra));
            if (tbl[k].we) chk($sformatf("r%0d.ram_wdata", k), 64'(a_rwd), 64'(tbl[k].rw));
        end

`ifdef AHB_SRAM_ERR_RESP_EN
        drive_a(Y, NS, N, SW, 32'h0004_0010, 32'h0);
        chk("err_oob.addr.cs",   64'(a_cs),   64'(0));
        chk("err_oob.addr.resp", 64'(a_resp), 64'(0));
        drive_a(Y, ID, N, SW, 32'h0, 32'h0);
        chk("err_oob.e1.rdy",  64'(a_rdy),  64'(0));
        chk("err_oob.e1.resp", 64'(a_resp), 64'(1));
        chk("err_oob.e1.cs",   64'(a_cs),   64'(0));
        drive_a(Y, ID, N, SW, 32'h0, 32'h0);
        chk("err_oob.e2.rdy",  64'(a_rdy),  64'(1));
        chk("err_oob.e2.resp", 64'(a_resp), 64'(1));
        chk("err_oob.e2.cs",   64'(a_cs),   64'(0));
        drive_a(Y, NS, Y, SW, 32'h13, 32'h0);
        chk("err_mis.addr.cs", 64'(a_cs), 64'(0));
        drive_a(Y, ID, N, SW, 32'h0, 32'h1122_3344);
        chk("err_mis.e1.rdy",  64'(a_rdy),  64'(0));
        chk("err_mis.e1.resp", 64'(a_resp), 64'(1));
        chk("err_mis.e1.cs",   64'(a_cs),   64'(0));
        drive_a(Y, ID, N, SW, 32'h0, 32'h0);
        chk("err_mis.e2.resp", 64'(a_resp), 64'(1));
        drive_a(Y, ID, N, SW, 32'h0, 32'h0);
        chk("err_mis.after.resp", 64'(a_resp), 64'(0));
        chk("err_mis.after.cs",   64'(a_cs),   64'(0));
        drive_a(Y, NS, N, SD, 32'h10, 32'h0);
        chk("err_size.addr.cs", 64'(a_cs), 64'(0));
        drive_a(Y, ID, N, SW, 32'h0, 32'h0);
        chk("err_size.e1.resp", 64'(a_resp), 64'(1));
        chk("err_size.e1.rdy",  64'(a_rdy),  64'(0));
        drive_a(Y, ID, N, SW, 32'h0, 32'h0);
`else
        drive_a(Y, NS, N, SW, 32'h0004_0010, 32'h0);
        chk("alias.cs",       64'(a_cs), 64'(1));
        chk("alias.ram_addr", 64'(a_ra), 64'(4));
        drive_a(Y, ID, N, SW, 32'h0, 32'h0);
        chk("alias.rdata", 64'(a_rd),   64'h0000_0000_A5A5_3C5A);
        chk("alias.resp",  64'(a_resp), 64'(0));
        drive_a(Y, NS, Y, SW, 32'h13, 32'h0);
        chk("trunc.addr.cs", 64'(a_cs), 64'(0));
        drive_a(Y, ID, N, SW, 32'h0, 32'h1122_3344);
        chk("trunc.cs",        64'(a_cs),  64'(1));
        chk("trunc.we",        64'(a_we),  64'(1));
        chk("trunc.be",        64'(a_be),  64'hF);
        chk("trunc.ram_addr",  64'(a_ra),  64'(4));
        chk("trunc.ram_wdata", 64'(a_rwd), 64'h0000_0000_1122_3344);
        drive_a(Y, NS, N, SW, 32'h10, 32'h0);
        drive_a(Y, ID, N, SW, 32'h0, 32'h0);
        chk("trunc.rdata", 64'(a_rd),   64'h0000_0000_1122_3344);
        chk("trunc.resp",  64'(a_resp), 64'(0));
`endif

        drive_b(NS, Y, SH, 32'h0E, 64'h0);
        chk("w64.addr.cs", 64'(b_cs), 64'(0));
        drive_b(NS, N, SD, 32'h20, 64'hBEEF_0000_0000_0000);
        chk("w64.rd.cs",       64'(b_cs),  64'(1));
        chk("w64.rd.we",       64'(b_we),  64'(0));
        chk("w64.rd.ram_addr", 64'(b_ra),  64'(4));
        chk("w64.rd.rdy",      64'(b_rdy), 64'(1));
        drive_b(ID, N, SD, 32'h0, 64'h0);
        chk("ws.w1.rdy",         64'(b_rdy),        64'(0));
        chk("w64.drain.cs",      64'(b_cs),         64'(1));
        chk("w64.drain.we",      64'(b_we),         64'(1));
        chk("w64.drain.be",      64'(b_be),         64'hC0);
        chk("w64.drain.wdata",   64'(b_rwd[63:48]), 64'hBEEF);
        chk("w64.drain.ram_addr", 64'(b_ra),        64'(1));
        drive_b(ID, N, SD, 32'h0, 64'h0);
        chk("ws.w2.rdy", 64'(b_rdy), 64'(0));
        chk("ws.w2.cs",  64'(b_cs),  64'(0));
        drive_b(ID, N, SD, 32'h0, 64'h0);
        chk("ws.data.rdy",   64'(b_rdy), 64'(1));
        chk("ws.data.rdata", b_rd,       64'hFACE_0004_0BAD_0004);
        chk("ws.data.resp",  64'(b_resp), 64'(0));
        drive_b(NS, N, SD, 32'h08, 64'h0);
        chk("r64.addr.rdata", b_rd, 64'h0);
        drive_b(ID, N, SD, 32'h0, 64'h0);
        chk("r64.w1.rdy", 64'(b_rdy), 64'(0));
        drive_b(ID, N, SD, 32'h0, 64'h0);
        chk("r64.w2.rdy", 64'(b_rdy), 64'(0));
        drive_b(ID, N, SD, 32'h0, 64'h0);
        chk("r64.data.rdy",   64'(b_rdy), 64'(1));
        chk("r64.data.rdata", b_rd,       64'hBEEF_0001_0BAD_0001);

        drive_b(NS, Y, SH, 32'h0E, 64'h0);
        drive_b(NS, N, SD, 32'h20, 64'h1111_0000_0000_0000);
        chk("rst_full.rd.cs", 64'(b_cs), 64'(1));
        @(posedge hclk);
        #1;
        hrst_b = 1'b0;
        b_tr = ID; a_tr = ID;
        #1;
        chk("rst_full.rdy",   64'(b_rdy),  64'(1));
        chk("rst_full.resp",  64'(b_resp), 64'(0));
        chk("rst_full.rdata", b_rd,        64'h0);
        chk("rst_full.cs",    64'(b_cs),   64'(0));
        chk("rst_full.we",    64'(b_we),   64'(0));
        chk("rst_full.be",    64'(b_be),   64'(0));
        @(negedge hclk);
        hrst_b = 1'b1;
        drive_b(ID, N, SD, 32'h0, 64'h0);
        chk("post_rst.cs",  64'(b_cs),  64'(0));
        chk("post_rst.rdy", 64'(b_rdy), 64'(1));
        drive_b(NS, N, SD, 32'h20, 64'h0);
        chk("post_rst.rd.cs",       64'(b_cs), 64'(1));
        chk("post_rst.rd.ram_addr", 64'(b_ra), 64'(4));
        drive_b(ID, N, SD, 32'h0, 64'h0);
        drive_b(ID, N, SD, 32'h0, 64'h0);
        drive_b(ID, N, SD, 32'h0, 64'h0);
        chk("post_rst.rdy",   64'(b_rdy), 64'(1));
        chk("post_rst.rdata", b_rd,       64'hFACE_0004_0BAD_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
